// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, FSM state encoding and the
// default operand/result limit. Used by the core and the keypad/display blocks.
package calc_pkg;

    localparam int unsigned MaxValDefault = 9999;

    localparam logic [3:0] KeyMaxDigit = 4'd9;
    localparam logic [3:0] KeyAdd      = 4'hA;
    localparam logic [3:0] KeySub      = 4'hB;
    localparam logic [3:0] KeyEq       = 4'hC;
    localparam logic [3:0] KeyClr      = 4'hD;

    typedef enum logic [2:0] {
        StEntryA,
        StOpWait,
        StEntryB,
        StResult,
        StErr
    } calc_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KeyMaxDigit;
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code == KeyAdd) || (code == KeySub);
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational add/subtract with range check.
//   a, b   : operands (0..MAX_VAL)
//   sub    : 1 = a - b, 0 = a + b
//   value  : result, forced to 0 when out of range
//   err    : sum above MAX_VAL or negative difference
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned MAX_VAL = MaxValDefault,
    parameter int unsigned W       = 14
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] value,
    output logic         err
);

    logic [W:0] sum;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        value = '0;
        err   = 1'b0;
        if (sub) begin
            if (a < b) begin
                err = 1'b1;
            end else begin
                value = a - b;
            end
        end else begin
            if (sum > (W+1)'(MAX_VAL)) begin
                err = 1'b1;
            end else begin
                value = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/calc_core.sv
// Four-function-style keypad calculator core (add/sub) with a display
// handshake towards a binary-to-digit converter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   key_valid, key_code : one-cycle key strobe and code
//   conv_done           : converter finished the previous conversion
//   num, error          : registered display value and error flag
//   convert             : one-cycle start pulse to the converter
module calc_core
    import calc_pkg::*;
#(
    parameter int unsigned MAX_VAL = MaxValDefault,
    parameter int unsigned W       = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         conv_done,
    output logic [W-1:0] num,
    output logic         error,
    output logic         convert
);

    calc_state_e  state_q, state_d;
    logic [W-1:0] acc_a_q, acc_a_d;
    logic [W-1:0] acc_b_q, acc_b_d;
    logic         op_sub_q, op_sub_d;
    logic         busy_q, busy_d;
    logic         pending_q, pending_d;
    logic [W-1:0] num_d;
    logic         error_d;
    logic         convert_d;

    logic [W-1:0] alu_value;
    logic         alu_err;

    calc_alu #(
        .MAX_VAL(MAX_VAL),
        .W      (W)
    ) u_alu (
        .a    (acc_a_q),
        .b    (acc_b_q),
        .sub  (op_sub_q),
        .value(alu_value),
        .err  (alu_err)
    );

    // Digit append as x*8 + x*2 + d, kept wide so overflow is caught by the compare.
    logic [W+3:0] app_a, app_b;
    logic         a_fits, b_fits;

    always_comb begin
        app_a  = ({4'b0, acc_a_q} << 3) + ({4'b0, acc_a_q} << 1) + (W+4)'(key_code);
        app_b  = ({4'b0, acc_b_q} << 3) + ({4'b0, acc_b_q} << 1) + (W+4)'(key_code);
        a_fits = app_a <= (W+4)'(MAX_VAL);
        b_fits = app_b <= (W+4)'(MAX_VAL);
    end

    function automatic logic [W-1:0] disp_val(input calc_state_e s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        if (s == StEntryB) return b;
        if (s == StErr) return '0;
        return a;
    endfunction

    // Key-driven FSM
    always_comb begin
        state_d  = state_q;
        acc_a_d  = acc_a_q;
        acc_b_d  = acc_b_q;
        op_sub_d = op_sub_q;
        if (key_valid) begin
            if (key_code == KeyClr) begin
                state_d = StEntryA;
                acc_a_d = '0;
                acc_b_d = '0;
            end else begin
                case (state_q)
                    StEntryA: begin
                        if (is_digit(key_code)) begin
                            if (a_fits) acc_a_d = app_a[W-1:0];
                        end else if (is_op(key_code)) begin
                            op_sub_d = (key_code == KeySub);
                            acc_b_d  = '0;
                            state_d  = StOpWait;
                        end
                    end
                    StOpWait: begin
                        if (is_digit(key_code)) begin
                            acc_b_d = W'(key_code);
                            state_d = StEntryB;
                        end else if (is_op(key_code)) begin
                            op_sub_d = (key_code == KeySub);
                        end
                    end
                    StEntryB: begin
                        if (is_digit(key_code)) begin
                            if (b_fits) acc_b_d = app_b[W-1:0];
                        end else if (is_op(key_code) || key_code == KeyEq) begin
                            if (alu_err) begin
                                acc_a_d = '0;
                                state_d = StErr;
                            end else begin
                                acc_a_d = alu_value;
                                if (is_op(key_code)) begin
                                    op_sub_d = (key_code == KeySub);
                                    state_d  = StOpWait;
                                end else begin
                                    state_d = StResult;
                                end
                            end
                        end
                    end
                    StResult: begin
                        if (is_digit(key_code)) begin
                            acc_a_d = W'(key_code);
                            state_d = StEntryA;
                        end else if (is_op(key_code)) begin
                            op_sub_d = (key_code == KeySub);
                            acc_b_d  = '0;
                            state_d  = StOpWait;
                        end
                    end
                    StErr: ;
                    default: state_d = StEntryA;
                endcase
            end
        end
    end

    // Display handshake. A conv_done arriving with a key frees the converter
    // first, so the key's new value can be issued straight away.
    logic [W-1:0] cur_num, nxt_num;
    logic         cur_err, nxt_err, change, idle, want;

    always_comb begin
        cur_num = disp_val(state_q, acc_a_q, acc_b_q);
        nxt_num = disp_val(state_d, acc_a_d, acc_b_d);
        cur_err = (state_q == StErr);
        nxt_err = (state_d == StErr);
        change  = (cur_num != nxt_num) || (cur_err != nxt_err);
        idle    = !busy_q || conv_done;
        want    = pending_q || change;

        convert_d = 1'b0;
        num_d     = num;
        error_d   = error;
        busy_d    = busy_q;
        pending_d = pending_q;
        if (idle && want) begin
            convert_d = 1'b1;
            num_d     = nxt_num;
            error_d   = nxt_err;
            busy_d    = 1'b1;
            pending_d = 1'b0;
        end else if (idle) begin
            busy_d = 1'b0;
        end else begin
            pending_d = want;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEntryA;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            op_sub_q  <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b1;  // forces an initial convert of 0 after reset
            num       <= '0;
            error     <= 1'b0;
            convert   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            op_sub_q  <= op_sub_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            num       <= num_d;
            error     <= error_d;
            convert   <= convert_d;
        end
    end

endmodule

// File: tb/tb_calc_core.sv
module tb_calc_core;

    localparam int unsigned W = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         conv_done;
    logic [W-1:0] num;
    logic         error;
    logic         convert;

    int n_checks = 0;
    int n_bad    = 0;
    int conv_cnt = 0;
    int last_num = 0;
    int last_err = 0;
    int ack_timer = 0;
    bit hold_ack = 1'b0;
    bit pending_ack = 1'b0;
    int c0;

    always #5 clk = ~clk;

    calc_core #(
        .MAX_VAL(9999),
        .W      (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .conv_done(conv_done),
        .num      (num),
        .error    (error),
        .convert  (convert)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Converter model: counts converts, acks after a short delay unless held.
    initial begin
        conv_done = 1'b0;
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            if (!rst_n) begin
                pending_ack = 1'b0;
            end else if (convert) begin
                conv_cnt++;
                last_num    = int'(num);
                last_err    = int'(error);
                ack_timer   = 1;
                pending_ack = 1'b1;
            end else if (pending_ack && !hold_ack) begin
                if (ack_timer == 0) begin
                    conv_done   = 1'b1;
                    pending_ack = 1'b0;
                end else begin
                    ack_timer--;
                end
            end
        end
    end

    task automatic press(input logic [3:0] c, input int settle);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (settle) @(negedge clk);
        #1;
    endtask

    task automatic keys(input logic [3:0] seq[$]);
        foreach (seq[i]) press(seq[i], 6);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_num", int'(num), 0);
        check_eq("rst_err", int'(error), 0);
        check_eq("rst_convert", int'(convert), 0);
        check_eq("rst_no_conv", conv_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_eq("rst_first_conv", conv_cnt, 1);
        check_eq("rst_first_num", last_num, 0);

        // Digit entry and 4-digit limit
        c0 = conv_cnt;
        press(4'd1, 6); check_eq("entry_1", int'(num), 1);
        press(4'd2, 6); check_eq("entry_12", int'(num), 12);
        press(4'd3, 6); check_eq("entry_123", int'(num), 123);
        press(4'd4, 6); check_eq("entry_1234", int'(num), 1234);
        press(4'd5, 6); check_eq("entry_5th_ignored", int'(num), 1234);
        check_eq("entry_conv_count", conv_cnt - c0, 4);

        // Overflow, error lock, clear
        keys('{4'hD, 4'd9, 4'd9, 4'd9, 4'd9, 4'hA, 4'd1, 4'hC});
        check_eq("ovf_err", int'(error), 1);
        check_eq("ovf_num", int'(num), 0);
        c0 = conv_cnt;
        press(4'd5, 6);
        check_eq("err_digit_num", int'(num), 0);
        check_eq("err_digit_err", int'(error), 1);
        check_eq("err_digit_noconv", conv_cnt - c0, 0);
        press(4'hD, 6);
        check_eq("clr_num", int'(num), 0);
        check_eq("clr_err", int'(error), 0);
        check_eq("clr_conv", conv_cnt - c0, 1);

        // Underflow, then chaining 20+30-5
        keys('{4'd5, 4'hB, 4'd7, 4'hC});
        check_eq("udf_err", int'(error), 1);
        check_eq("udf_num", int'(num), 0);
        keys('{4'hD, 4'd2, 4'd0, 4'hA, 4'd3, 4'd0, 4'hB, 4'd5, 4'hC});
        check_eq("chain_num", int'(num), 45);
        check_eq("chain_err", int'(error), 0);
        press(4'd7, 6);
        check_eq("result_new_entry", int'(num), 7);

        // Boundaries: exact maximum, zero difference, op replaced in OP_WAIT
        keys('{4'hD, 4'd9, 4'd9, 4'd9, 4'd0, 4'hA, 4'd9, 4'hC});
        check_eq("max_sum_num", int'(num), 9999);
        check_eq("max_sum_err", int'(error), 0);
        keys('{4'hD, 4'd5, 4'hB, 4'd5, 4'hC});
        check_eq("zero_diff_num", int'(num), 0);
        check_eq("zero_diff_err", int'(error), 0);
        keys('{4'hD, 4'd8, 4'hA, 4'hB, 4'd3, 4'hC});
        check_eq("op_replace", int'(num), 5);

        // Coalescing while the converter is held off
        press(4'hD, 6);
        hold_ack = 1'b1;
        c0 = conv_cnt;
        press(4'd1, 0);
        press(4'd2, 0);
        press(4'd3, 0);
        repeat (20) @(negedge clk);
        #1;
        check_eq("busy_one_conv", conv_cnt - c0, 1);
        check_eq("busy_num_held", int'(num), 1);
        hold_ack = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check_eq("coalesce_conv", conv_cnt - c0, 2);
        check_eq("coalesce_num", last_num, 123);

        // Reset in the middle of a conversion
        keys('{4'hD, 4'd7});
        hold_ack = 1'b1;
        press(4'd7, 3);
        check_eq("pre_rst_num", int'(num), 77);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_num", int'(num), 0);
        check_eq("async_rst_err", int'(error), 0);
        check_eq("async_rst_convert", int'(convert), 0);
        hold_ack    = 1'b0;
        pending_ack = 1'b0;
        c0 = conv_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_eq("post_rst_conv", conv_cnt - c0, 1);
        check_eq("post_rst_num", last_num, 0);
        check_eq("post_rst_err", last_err, 0);
        press(4'd3, 6);
        check_eq("post_rst_entry", int'(num), 3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
